// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage MIPS pipeline.
// Holds the instruction handed over by execute, captures the synchronous
// data-SRAM read word and turns it into an aligned, extended load result
// with a per-byte register write strobe. It also forwards the result to decode
// and reports exceptions back to execute.
module mem_stage (
    input  logic         clk,
    input  logic         resetn,
    // handshake with write-back
    input  logic         ws_allowin,
    output logic         ms_allowin,
    // from execute
    input  logic         es_to_ms_valid,
    input  logic [127:0] es_to_ms_bus,
    // synchronous data SRAM read port
    input  logic [31:0]  data_sram_rdata,
    // to write-back
    output logic         ms_to_ws_valid,
    output logic [123:0] ms_to_ws_bus,
    // forwarding to decode, exception flag to execute
    output logic [38:0]  ms_fwd_bus,
    output logic         ms_ex,
    // exception / eret flush from write-back
    input  logic         flush
);

    localparam int ES_TO_MS_BUS_WD = 128;
    localparam int MS_TO_WS_BUS_WD = 124;
    localparam int MS_FWD_BUS_WD   = 39;

    // One-hot load-type positions inside the ld_inst field.
    localparam int LD_LW  = 6;
    localparam int LD_LB  = 5;
    localparam int LD_LBU = 4;
    localparam int LD_LH  = 3;
    localparam int LD_LHU = 2;
    localparam int LD_LWL = 1;
    localparam int LD_LWR = 0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                       ms_valid_q,  ms_valid_d;
    logic                       ms_first_q,  ms_first_d;
    logic [31:0]                rdata_buf_q, rdata_buf_d;
    logic [ES_TO_MS_BUS_WD-1:0] es_bus_q,    es_bus_d;

    // ------------------------------------------------------------------
    // Fields of the held execute bus
    // ------------------------------------------------------------------
    logic [31:0] ms_badvaddr;
    logic [10:0] ms_c0_bus;
    logic        ms_bd;
    logic        ms_ex_bit;
    logic [4:0]  ms_excode;
    logic [6:0]  ms_ld_inst;
    logic        ms_res_from_mem;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_res;
    logic [31:0] ms_pc;

    assign {ms_badvaddr,
            ms_c0_bus,
            ms_bd,
            ms_ex_bit,
            ms_excode,
            ms_ld_inst,
            ms_res_from_mem,
            ms_gr_we,
            ms_dest,
            ms_res,
            ms_pc} = es_bus_q;

    // ------------------------------------------------------------------
    // Load alignment helpers
    // ------------------------------------------------------------------

    // Aligned/extended load value for byte offset p within the read word.
    function automatic logic [31:0] load_align(input logic [6:0]  ld,
                                               input logic [1:0]  p,
                                               input logic [31:0] w);
        logic [31:0] byte_sh;
        logic [15:0] half;
        logic [31:0] r;
        byte_sh = w >> {p, 3'b000};
        half    = p[1] ? w[31:16] : w[15:0];
        if (ld[LD_LW]) begin
            r = w;
        end else if (ld[LD_LB]) begin
            r = {{24{byte_sh[7]}}, byte_sh[7:0]};
        end else if (ld[LD_LBU]) begin
            r = {24'h000000, byte_sh[7:0]};
        end else if (ld[LD_LH]) begin
            r = {{16{half[15]}}, half};
        end else if (ld[LD_LHU]) begin
            r = {16'h0000, half};
        end else if (ld[LD_LWL]) begin
            // 8*(3-p) equals 8*~p for a 2-bit offset
            r = w << {~p, 3'b000};
        end else if (ld[LD_LWR]) begin
            r = w >> {p, 3'b000};
        end else begin
            r = w;
        end
        return r;
    endfunction

    // Register write strobe: only lwl/lwr write a partial register.
    function automatic logic [3:0] load_strb(input logic [6:0] ld,
                                             input logic [1:0] p);
        logic [3:0] s;
        if (ld[LD_LWL]) begin
            case (p)
                2'd0:    s = 4'b1000;
                2'd1:    s = 4'b1100;
                2'd2:    s = 4'b1110;
                default: s = 4'b1111;
            endcase
        end else if (ld[LD_LWR]) begin
            case (p)
                2'd0:    s = 4'b1111;
                2'd1:    s = 4'b0111;
                2'd2:    s = 4'b0011;
                default: s = 4'b0001;
            endcase
        end else begin
            s = 4'b1111;
        end
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Handshake (this stage never needs more than one cycle)
    // ------------------------------------------------------------------
    assign ms_allowin     = !ms_valid_q || ws_allowin;
    assign ms_to_ws_valid = ms_valid_q && !flush;
    assign ms_ex          = ms_valid_q && ms_ex_bit;

    // Next-state logic for valid, first-cycle flag, read buffer and bus register.
    always_comb begin
        ms_valid_d = ms_valid_q;
        if (flush) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end

        es_bus_d = es_bus_q;
        if (es_to_ms_valid && ms_allowin) begin
            es_bus_d = es_to_ms_bus;
        end

        // The SRAM word is only valid in the cycle right after the request,
        // so it is buffered then and replayed for as long as the stage stalls.
        ms_first_d  = es_to_ms_valid && ms_allowin && !flush;
        rdata_buf_d = ms_first_q ? data_sram_rdata : rdata_buf_q;
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid_q  <= 1'b0;
            ms_first_q  <= 1'b0;
            rdata_buf_q <= 32'h0;
            es_bus_q    <= '0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            ms_first_q  <= ms_first_d;
            rdata_buf_q <= rdata_buf_d;
            es_bus_q    <= es_bus_d;
        end
    end

    // ------------------------------------------------------------------
    // Result formation
    // ------------------------------------------------------------------
    logic [31:0] rd_word;
    logic [31:0] ms_result;
    logic [3:0]  ms_wstrb_raw;
    logic [3:0]  ms_rf_wstrb;
    logic        ms_gr_we_out;

    assign rd_word      = ms_first_q ? data_sram_rdata : rdata_buf_q;
    assign ms_result    = ms_res_from_mem ? load_align(ms_ld_inst, ms_res[1:0], rd_word)
                                          : ms_res;
    assign ms_wstrb_raw = ms_res_from_mem ? load_strb(ms_ld_inst, ms_res[1:0])
                                          : 4'b1111;
    // An excepting instruction must not touch the register file. The strobe
    // is also zeroed for an empty stage so the idle bus is all zeros.
    assign ms_rf_wstrb  = (ms_ex_bit || !ms_valid_q) ? 4'b0000 : ms_wstrb_raw;
    assign ms_gr_we_out = ms_gr_we && !ms_ex_bit;

    logic [MS_TO_WS_BUS_WD-1:0] ws_bus;
    assign ws_bus = {ms_badvaddr,
                     ms_c0_bus,
                     ms_bd,
                     ms_ex_bit,
                     ms_excode,
                     ms_rf_wstrb,
                     ms_gr_we_out,
                     ms_dest,
                     ms_result,
                     ms_pc};
    assign ms_to_ws_bus = ws_bus;

    // ------------------------------------------------------------------
    // Forwarding to decode: loads are fully resolved here, so the aligned
    // value is forwarded directly and decode never waits on this stage.
    // ------------------------------------------------------------------
    logic                     fwd_block_valid;
    logic                     fwd_mfc0_valid;
    logic [MS_FWD_BUS_WD-1:0] fwd_bus;

    assign fwd_block_valid = ms_valid_q && ms_gr_we && !ms_ex_bit && !flush;
    assign fwd_mfc0_valid  = ms_valid_q && ms_c0_bus[8];
    assign fwd_bus         = {fwd_mfc0_valid, fwd_block_valid, ms_dest, ms_result};
    assign ms_fwd_bus      = fwd_bus;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven, scoreboard-checked bench for mem_stage.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [127:0] es_to_ms_bus;
    logic [31:0]  data_sram_rdata;
    logic         ms_to_ws_valid;
    logic [123:0] ms_to_ws_bus;
    logic [38:0]  ms_fwd_bus;
    logic         ms_ex;
    logic         flush;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_fwd_bus      (ms_fwd_bus),
        .ms_ex           (ms_ex),
        .flush           (flush)
    );

    localparam logic [6:0] LD_NONE = 7'b0000000;
    localparam logic [6:0] LD_LW   = 7'b1000000;
    localparam logic [6:0] LD_LB   = 7'b0100000;
    localparam logic [6:0] LD_LBU  = 7'b0010000;
    localparam logic [6:0] LD_LH   = 7'b0001000;
    localparam logic [6:0] LD_LHU  = 7'b0000100;
    localparam logic [6:0] LD_LWL  = 7'b0000010;
    localparam logic [6:0] LD_LWR  = 7'b0000001;

    typedef struct {
        logic [6:0]  ld;
        logic [31:0] res;
        logic [31:0] rdata;
        logic        ex;
        logic [4:0]  excode;
        logic        gr_we;
        logic [10:0] c0;
        logic [31:0] exp_result;
        logic [3:0]  exp_wstrb;
        logic        exp_gr_we;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [3:0]  wstrb;
        logic        gr_we;
        logic        ex;
        logic [4:0]  excode;
        logic        mfc0;
        logic [31:0] badvaddr;
    } exp_t;

    localparam int NV = 17;
    vec_t vecs[NV];
    exp_t sbq[$];
    exp_t mon_e;
    exp_t drv_e;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_bus(input vec_t v, input logic [31:0] pc,
                                            input logic [4:0] dest);
        return {v.res, v.c0, 1'b0, v.ex, v.excode, v.ld, (v.ld != LD_NONE),
                v.gr_we, dest, v.res, pc};
    endfunction

    function automatic exp_t mk_exp(input vec_t v, input logic [31:0] pc,
                                    input logic [4:0] dest);
        exp_t e;
        e.pc       = pc;
        e.dest     = dest;
        e.result   = v.exp_result;
        e.wstrb    = v.exp_wstrb;
        e.gr_we    = v.exp_gr_we;
        e.ex       = v.ex;
        e.excode   = v.excode;
        e.mfc0     = v.c0[8];
        e.badvaddr = v.res;
        return e;
    endfunction

    // Scoreboard: compare every instruction write-back accepts.
    always @(negedge clk) begin
        if (resetn && ms_to_ws_valid && ws_allowin) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got pc %0h expected no instruction",
                         ms_to_ws_bus[31:0]);
            end else begin
                mon_e = sbq.pop_front();
                chk("pc",          128'(ms_to_ws_bus[31:0]),    128'(mon_e.pc));
                chk("result",      128'(ms_to_ws_bus[63:32]),   128'(mon_e.result));
                chk("dest",        128'(ms_to_ws_bus[68:64]),   128'(mon_e.dest));
                chk("gr_we",       128'(ms_to_ws_bus[69]),      128'(mon_e.gr_we));
                chk("rf_wstrb",    128'(ms_to_ws_bus[73:70]),   128'(mon_e.wstrb));
                chk("excode",      128'(ms_to_ws_bus[78:74]),   128'(mon_e.excode));
                chk("ex_field",    128'(ms_to_ws_bus[79]),      128'(mon_e.ex));
                chk("badvaddr",    128'(ms_to_ws_bus[123:92]),  128'(mon_e.badvaddr));
                chk("ms_ex",       128'(ms_ex),                 128'(mon_e.ex));
                chk("block_valid", 128'(ms_fwd_bus[37]),        128'(mon_e.gr_we));
                chk("mfc0_valid",  128'(ms_fwd_bus[38]),        128'(mon_e.mfc0));
                chk("fwd_dest",    128'(ms_fwd_bus[36:32]),     128'(mon_e.dest));
                chk("fwd_result",  128'(ms_fwd_bus[31:0]),      128'(mon_e.result));
            end
        end
    end

    // Global time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before limit");
        $fatal(1, "time limit");
    end

    vec_t vs;

    initial begin
        //            ld       res           rdata         ex    excode  gr_we  c0       exp_result    wstrb    gr_we
        vecs[0]  = '{LD_LB,   32'h00000102, 32'h8899AABB, 1'b0, 5'h00, 1'b1, 11'h000, 32'hFFFFFF99, 4'b1111, 1'b1};
        vecs[1]  = '{LD_LBU,  32'h00000102, 32'h8899AABB, 1'b0, 5'h00, 1'b1, 11'h000, 32'h00000099, 4'b1111, 1'b1};
        vecs[2]  = '{LD_LH,   32'h00000102, 32'h8899AABB, 1'b0, 5'h00, 1'b1, 11'h000, 32'hFFFF8899, 4'b1111, 1'b1};
        vecs[3]  = '{LD_LHU,  32'h00000100, 32'h8899AABB, 1'b0, 5'h00, 1'b1, 11'h000, 32'h0000AABB, 4'b1111, 1'b1};
        vecs[4]  = '{LD_LWL,  32'h00000101, 32'h11223344, 1'b0, 5'h00, 1'b1, 11'h000, 32'h33440000, 4'b1100, 1'b1};
        vecs[5]  = '{LD_LWR,  32'h00000101, 32'h11223344, 1'b0, 5'h00, 1'b1, 11'h000, 32'h00112233, 4'b0111, 1'b1};
        vecs[6]  = '{LD_LW,   32'h00000200, 32'hCAFEF00D, 1'b0, 5'h00, 1'b1, 11'h000, 32'hCAFEF00D, 4'b1111, 1'b1};
        vecs[7]  = '{LD_LWL,  32'h00000103, 32'h11223344, 1'b0, 5'h00, 1'b1, 11'h000, 32'h11223344, 4'b1111, 1'b1};
        vecs[8]  = '{LD_LWR,  32'h00000103, 32'h11223344, 1'b0, 5'h00, 1'b1, 11'h000, 32'h00000011, 4'b0001, 1'b1};
        vecs[9]  = '{LD_LWL,  32'h00000100, 32'h11223344, 1'b0, 5'h00, 1'b1, 11'h000, 32'h44000000, 4'b1000, 1'b1};
        vecs[10] = '{LD_LB,   32'h00000100, 32'h8899AABB, 1'b0, 5'h00, 1'b1, 11'h000, 32'hFFFFFFBB, 4'b1111, 1'b1};
        vecs[11] = '{LD_LH,   32'h00000100, 32'h12347FFF, 1'b0, 5'h00, 1'b1, 11'h000, 32'h00007FFF, 4'b1111, 1'b1};
        vecs[12] = '{LD_NONE, 32'h12345678, 32'hFFFFFFFF, 1'b0, 5'h00, 1'b1, 11'h100, 32'h12345678, 4'b1111, 1'b1};
        vecs[13] = '{LD_NONE, 32'hABCD0000, 32'h00000000, 1'b1, 5'h04, 1'b1, 11'h000, 32'hABCD0000, 4'b0000, 1'b0};
        vecs[14] = '{LD_LWR,  32'h00000100, 32'h11223344, 1'b0, 5'h00, 1'b1, 11'h000, 32'h11223344, 4'b1111, 1'b1};
        vecs[15] = '{LD_LBU,  32'h00000103, 32'h8899AABB, 1'b0, 5'h00, 1'b1, 11'h000, 32'h00000088, 4'b1111, 1'b1};
        vecs[16] = '{LD_LHU,  32'h00000102, 32'h8899AABB, 1'b0, 5'h00, 1'b0, 11'h000, 32'h00008899, 4'b1111, 1'b0};

        resetn          = 1'b0;
        ws_allowin      = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        data_sram_rdata = 32'h0;
        flush           = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_allowin",  128'(ms_allowin),     128'(1'b1));
        chk("rst_valid",    128'(ms_to_ws_valid), 128'(1'b0));
        chk("rst_ms_ex",    128'(ms_ex),          128'(1'b0));
        chk("rst_fwd_bus",  128'(ms_fwd_bus),     128'(39'h0));
        chk("rst_ws_bus",   128'(ms_to_ws_bus),   128'(124'h0));
        @(posedge clk); #1;
        resetn = 1'b1;

        // Back-to-back table stream; read data follows each request by one cycle.
        @(posedge clk); #1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(vecs[0], 32'h00001000, 5'd1);
        sbq.push_back(mk_exp(vecs[0], 32'h00001000, 5'd1));
        for (int i = 1; i <= NV; i++) begin
            @(posedge clk); #1;
            data_sram_rdata = vecs[i-1].rdata;
            if (i < NV) begin
                es_to_ms_bus = mk_bus(vecs[i], 32'h00001000 + 32'(4 * i), 5'(i + 1));
                sbq.push_back(mk_exp(vecs[i], 32'h00001000 + 32'(4 * i), 5'(i + 1)));
            end else begin
                es_to_ms_valid = 1'b0;
            end
        end

        // Stall: the first-cycle word must be held while SRAM data changes.
        @(posedge clk); #1;
        vs = '{LD_LW, 32'h00000300, 32'h5A5A1234, 1'b0, 5'h00, 1'b1, 11'h000,
               32'h5A5A1234, 4'b1111, 1'b1};
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(vs, 32'h00002000, 5'd7);
        sbq.push_back(mk_exp(vs, 32'h00002000, 5'd7));
        @(posedge clk); #1;
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h5A5A1234;
        ws_allowin      = 1'b0;
        @(negedge clk);
        chk("stall1_allowin", 128'(ms_allowin),          128'(1'b0));
        chk("stall1_valid",   128'(ms_to_ws_valid),      128'(1'b1));
        chk("stall1_result",  128'(ms_to_ws_bus[63:32]), 128'(32'h5A5A1234));
        @(posedge clk); #1;
        data_sram_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("stall2_result",  128'(ms_to_ws_bus[63:32]), 128'(32'h5A5A1234));
        chk("stall2_pc",      128'(ms_to_ws_bus[31:0]),  128'(32'h00002000));
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall3_result",  128'(ms_to_ws_bus[63:32]), 128'(32'h5A5A1234));
        chk("stall3_allowin", 128'(ms_allowin),          128'(1'b0));
        @(posedge clk); #1;
        ws_allowin = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_stall_valid", 128'(ms_to_ws_valid), 128'(1'b0));

        // Flush while an add is held and a new instruction is presented.
        @(posedge clk); #1;
        vs = '{LD_NONE, 32'h00000111, 32'h0, 1'b0, 5'h00, 1'b1, 11'h000,
               32'h00000111, 4'b1111, 1'b1};
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(vs, 32'h00003000, 5'd9);
        @(posedge clk); #1;
        es_to_ms_valid = 1'b0;
        ws_allowin     = 1'b0;
        @(negedge clk);
        chk("hold_valid",       128'(ms_to_ws_valid), 128'(1'b1));
        chk("hold_block_valid", 128'(ms_fwd_bus[37]), 128'(1'b1));
        @(posedge clk); #1;
        flush          = 1'b1;
        ws_allowin     = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(vs, 32'h00003004, 5'd10);
        @(negedge clk);
        chk("flush_valid",       128'(ms_to_ws_valid), 128'(1'b0));
        chk("flush_block_valid", 128'(ms_fwd_bus[37]), 128'(1'b0));
        @(posedge clk); #1;
        flush          = 1'b0;
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("after_flush_valid",   128'(ms_to_ws_valid), 128'(1'b0));
        chk("after_flush_allowin", 128'(ms_allowin),     128'(1'b1));
        repeat (3) @(posedge clk);

        // Reset in the middle of a stall discards the held instruction.
        #1;
        vs = '{LD_NONE, 32'h00000444, 32'h0, 1'b1, 5'h0C, 1'b1, 11'h100,
               32'h00000444, 4'b0000, 1'b0};
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_bus(vs, 32'h00004000, 5'd3);
        @(posedge clk); #1;
        es_to_ms_valid = 1'b0;
        ws_allowin     = 1'b0;
        @(negedge clk);
        chk("ex_held_ms_ex",   128'(ms_ex),                 128'(1'b1));
        chk("ex_held_gr_we",   128'(ms_to_ws_bus[69]),      128'(1'b0));
        chk("ex_held_excode",  128'(ms_to_ws_bus[78:74]),   128'(5'h0C));
        chk("ex_held_mfc0",    128'(ms_fwd_bus[38]),        128'(1'b1));
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("rst2_valid",   128'(ms_to_ws_valid), 128'(1'b0));
        chk("rst2_allowin", 128'(ms_allowin),     128'(1'b1));
        chk("rst2_ms_ex",   128'(ms_ex),          128'(1'b0));
        chk("rst2_fwd_bus", 128'(ms_fwd_bus),     128'(39'h0));
        chk("rst2_ws_bus",  128'(ms_to_ws_bus),   128'(124'h0));
        ws_allowin = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        chk("scoreboard_empty", 128'(sbq.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Fourth stage of the five-stage MIPS pipeline, between the execute and write-back stages. It holds the instruction issued by execute and captures the synchronous data-SRAM read word, which arrives one cycle after the request. It aligns and extends load data (lw/lb/lbu/lh/lhu/lwl/lwr) and passes results, exception state and CP0 control to write-back. It also drives a forwarding bus to decode and an exception flag back to execute.

## Interface
- No parameters; widths fixed: ES_TO_MS_BUS_WD = 128, MS_TO_WS_BUS_WD = 124, MS_FWD_BUS_WD = 39.
- clk  in  1  sole clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- ws_allowin  in  1  write-back can accept an instruction this cycle.
- ms_allowin  out  1  this stage can accept from execute.
- es_to_ms_valid  in  1  execute presents a valid instruction.
- es_to_ms_bus  in  128  fields, msb to lsb:
  - badvaddr[127:96], c0_bus[95:85], bd[84], ex[83], excode[82:78]
  - ld_inst[77:71] = {lw,lb,lbu,lh,lhu,lwl,lwr}
  - res_from_mem[70], gr_we[69], dest[68:64], res[63:32], pc[31:0]
- data_sram_rdata  in  32  read word for the address issued by execute in the previous cycle.
- ms_to_ws_valid  out  1  valid instruction offered to write-back.
- ms_to_ws_bus  out  124  fields, msb to lsb:
  - badvaddr[123:92], c0_bus[91:81], bd[80], ex[79], excode[78:74]
  - rf_wstrb[73:70], gr_we[69], dest[68:64], result[63:32], pc[31:0]
- ms_fwd_bus  out  39  {mfc0_valid[38], block_valid[37], dest[36:32], result[31:0]}.
- ms_ex  out  1  valid instruction in this stage carries an exception.
- flush  in  1  exception/eret flush from write-back.

## Operation
- Handshake:
  - ms_ready_go = 1.
  - ms_allowin = !ms_valid || ws_allowin.
  - ms_to_ws_valid = ms_valid && !flush.
- ms_valid update:
  - cleared on reset or flush;
  - otherwise, when ms_allowin, loads es_to_ms_valid.
- Bus register loads es_to_ms_bus when es_to_ms_valid && ms_allowin.
- Read-data capture:
  - Flag ms_first is set in the cycle an instruction enters and cleared the following cycle.
  - rd_word = ms_first ? data_sram_rdata : rdata_buf.
  - rdata_buf loads data_sram_rdata at the end of any ms_first cycle. SRAM data is therefore stable across any stall length.
- Load alignment uses p = res[1:0] and b_k = byte k of rd_word:
  - lw: word, strobe 1111.
  - lb / lbu: b_p sign- or zero-extended, strobe 1111.
  - lh / lhu: halfword at byte 2·p[1], sign- or zero-extended, strobe 1111.
  - lwl: rd_word << (8·(3−p)); strobe 1000, 1100, 1110, 1111 for p = 0..3.
  - lwr: rd_word >> (8·p); strobe 1111, 0111, 0011, 0001 for p = 0..3.
  - Write-back merges strobed bytes with the old register value.
- Non-load instructions: result = res, rf_wstrb = 1111.
- Exceptions:
  - ms_ex = ms_valid && ex.
  - When ex = 1, the outgoing gr_we is forced 0 and rf_wstrb is forced 0000; all other fields pass through unchanged.
- Forwarding:
  - block_valid = ms_valid && gr_we && !ex && !flush.
  - mfc0_valid = ms_valid && c0_bus[8].
  - result is the aligned value; loads are fully resolved here, so decode never stalls on a load sitting in this stage.

## Timing
- Reset (resetn = 0 at an edge):
  - ms_valid = 0, ms_first = 0; rdata_buf and the bus register are cleared to 0.
  - Outputs: ms_allowin = 1, ms_to_ws_valid = 0, ms_ex = 0, ms_fwd_bus = 0, ms_to_ws_bus = 0.
- Latency: one cycle per instruction when unstalled. An instruction accepted at edge N is offered at N+1.
- Back-to-back: entry on the same edge as exit is legal; ms_first is set again for the new instruction.
- Stall (ws_allowin = 0):
  - bus register and ms_valid hold;
  - ms_allowin = 0;
  - the offered bus stays constant every cycle.
- Flush: ms_to_ws_valid and block_valid drop combinationally in the same cycle; ms_valid = 0 after the edge. A flush coinciding with an incoming es_to_ms_valid discards the incoming instruction.
- Reset during a stall discards the instruction; no output is valid in the next cycle.

## Test plan
- lb, res[1:0] = 2, rdata 0x8899AABB → result 0xFFFFFF99, wstrb 1111. Same with lbu → 0x00000099. lh at p = 2 → 0xFFFF8899.
- lwl at p = 1 with rdata 0x11223344 → result 0x33440000, wstrb 1100. lwr at p = 1 → 0x00112233, wstrb 0111.
- lw accepted, ws_allowin held low 3 cycles, data_sram_rdata changed to 0xDEADBEEF after the first cycle → output stays at the first-cycle word throughout; released on the 4th cycle.
- Instruction with ex = 1, excode 0x04, gr_we = 1 → ms_ex = 1, outgoing gr_we = 0, wstrb 0000, block_valid = 0, excode 0x04 unchanged.
- flush asserted while a valid add is held and a new instruction is presented → ms_to_ws_valid = 0 in that cycle, ms_valid = 0 next cycle, the new instruction never appears.
- resetn low mid-stall → next cycle all outputs at reset values, ms_allowin = 1.
